// File: rtl/vga_capture.sv
// Receive side of a VGA-timed link: recovers pixel coordinates, checks line/frame geometry,
// and forwards a qualified pixel stream once enough consecutive frames are geometrically clean.
module vga_capture #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       i_clk_25M,
  input  logic       i_rst,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_blank_n,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic       o_pix_valid,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_sof,
  output logic       o_eol,
  output logic       o_locked,
  output logic       o_err
);

  typedef enum logic [1:0] {IDLE, TRAIN, LOCK} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [9:0] H_ACT_C  = 10'(H_ACT);
  localparam logic [9:0] H_LAST_C = 10'(H_ACT - 1);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACT);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [3:0] LOCK_C   = 4'(LOCK_FRAMES);

  // stage 1: input registers and sync-edge history
  logic hs_s1, vs_s1, blank_s1;
  logic vs_hist, blank_hist;
  rgb_t rgb_s1;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      hs_s1      <= 1'b1;
      vs_s1      <= 1'b1;
      blank_s1   <= 1'b0;
      rgb_s1     <= '0;
      vs_hist    <= 1'b1;
      blank_hist <= 1'b1;
    end else begin
      hs_s1      <= i_hs;
      vs_s1      <= i_vs;
      blank_s1   <= i_blank_n;
      rgb_s1     <= '{r: i_r, g: i_g, b: i_b};
      vs_hist    <= vs_s1;
      blank_hist <= blank_s1;
    end
  end

  // HS is carried through stage 1 but not checked.
  logic hs_unused;
  assign hs_unused = hs_s1;

  logic vs_fall, blank_fall;
  assign vs_fall    = vs_hist & ~vs_s1;
  assign blank_fall = blank_hist & ~blank_s1;

  // position counters; x_cnt/y_cnt hold the coordinate of the current stage-1 pixel
  logic [9:0] x_cnt, y_cnt;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (vs_fall) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (blank_fall) begin
      x_cnt <= '0;
      if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 10'd1;
    end else if (blank_s1) begin
      if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 10'd1;
    end
  end

  logic line_err, extra_line_err, vs_err, geo_err;
  assign line_err       = blank_fall & (x_cnt != H_ACT_C);
  assign extra_line_err = blank_s1 & (y_cnt >= V_ACT_C);
  assign vs_err         = vs_fall & ((y_cnt != V_ACT_C) | blank_s1);
  assign geo_err        = line_err | extra_line_err | vs_err;

  // FSM; frame_bad marks a training frame already known to be broken
  state_t     state_q, state_d;
  logic [3:0] good_q, good_d;
  logic       bad_q, bad_d;
  logic       fwd, err_pulse;
  logic [3:0] good_inc;

  assign good_inc = good_q + 4'd1;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      state_q <= IDLE;
      good_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;
    fwd       = 1'b0;
    err_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_fall) begin
          state_d = TRAIN;
          good_d  = '0;
          bad_d   = 1'b0;
        end
      end
      TRAIN: begin
        if (vs_fall) begin
          // an error on the closing VS edge still spoils the finished frame
          bad_d = 1'b0;
          if (geo_err || bad_q) begin
            good_d = '0;
          end else begin
            good_d = good_inc;
            if (good_inc >= LOCK_C) state_d = LOCK;
          end
        end else if (geo_err) begin
          good_d = '0;
          bad_d  = 1'b1;
        end
      end
      LOCK: begin
        if (geo_err) begin
          err_pulse = 1'b1;
          good_d    = '0;
          state_d   = TRAIN;
          bad_d     = ~vs_fall;
        end else begin
          fwd = blank_s1;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
        bad_d   = 1'b0;
      end
    endcase
  end

  // stage 2: registered outputs, zeroed whenever the pixel is not forwarded
  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      o_pix_valid <= 1'b0;
      o_pix_x     <= '0;
      o_pix_y     <= '0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_sof       <= 1'b0;
      o_eol       <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_pix_valid <= fwd;
      o_pix_x     <= fwd ? x_cnt : '0;
      o_pix_y     <= fwd ? y_cnt : '0;
      o_r         <= fwd ? rgb_s1.r : '0;
      o_g         <= fwd ? rgb_s1.g : '0;
      o_b         <= fwd ? rgb_s1.b : '0;
      o_sof       <= fwd & (x_cnt == '0) & (y_cnt == '0);
      o_eol       <= fwd & (x_cnt == H_LAST_C);
      o_err       <= err_pulse;
    end
  end

  assign o_locked = (state_q == LOCK);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken 4x3 geometry: lock, coordinates, latency,
// short line, extra line, mid-line reset and VS-during-active errors.
module tb_vga_capture;
  localparam int H = 4;
  localparam int V = 3;

  logic       clk = 1'b0;
  logic       rst, hs, vs, blank;
  logic [7:0] r, g, b;
  logic       o_pix_valid, o_sof, o_eol, o_locked, o_err;
  logic [9:0] o_pix_x, o_pix_y;
  logic [7:0] o_r, o_g, o_b;

  vga_capture #(.H_ACT(H), .V_ACT(V), .LOCK_FRAMES(2)) dut (
    .i_clk_25M(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_blank_n(blank),
    .i_r(r), .i_g(g), .i_b(b),
    .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_sof(o_sof), .o_eol(o_eol), .o_locked(o_locked), .o_err(o_err)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  int   n_valid = 0, n_eol = 0, n_sof = 0, n_err = 0, n_bad = 0;
  int   sof_cyc = -1, lock_rise = -1;
  logic lock_prev = 1'b0;

  always @(negedge clk) begin
    if (o_pix_valid === 1'b1) n_valid <= n_valid + 1;
    n_bad <= n_bad
           + ((o_pix_valid === 1'b1 && (o_r !== o_pix_x[7:0] || o_g !== o_pix_y[7:0] ||
               o_b !== 8'h5A)) ? 1 : 0)
           + (((o_sof === 1'b1 || o_eol === 1'b1) && o_pix_valid !== 1'b1) ? 1 : 0);
    if (o_eol === 1'b1) n_eol <= n_eol + 1;
    if (o_sof === 1'b1) begin
      n_sof   <= n_sof + 1;
      sof_cyc <= cyc;
    end
    if (o_err === 1'b1) n_err <= n_err + 1;
    if (o_locked === 1'b1 && lock_prev !== 1'b1) lock_rise <= cyc;
    lock_prev <= o_locked;
  end

  int checks = 0, failures = 0;
  int b_valid, b_eol, b_sof, b_err, b_bad;
  int vs_drv, fpx_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic bl, input logic [7:0] rr, input logic [7:0] gg);
    vs = v; blank = bl; r = rr; g = gg;
    @(posedge clk); #1;
  endtask

  task automatic snap();
    b_valid = n_valid; b_eol = n_eol; b_sof = n_sof; b_err = n_err; b_bad = n_bad;
  endtask

  // one frame: 2 VS-low cycles, 2 porch cycles, nlines lines of H pixels + 2 blank cycles
  task automatic frame(input int nlines, input int short_ln, input int rst_ln, input bit vs_act);
    vs_drv = cyc;
    drive(1'b0, vs_act, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    for (int ln = 0; ln < nlines; ln++) begin
      for (int px = 0; px < ((ln == short_ln) ? H - 1 : H); px++) begin
        if (ln == 0 && px == 0) fpx_drv = cyc;
        if (ln == rst_ln && px == 2) begin
          chk("pre_rst_locked", o_locked, 1);
          rst = 1'b1;
          drive(1'b1, 1'b1, 8'(px), 8'(ln));
          rst = 1'b0;
          chk("midrst_ctrl", {o_pix_valid, o_sof, o_eol, o_locked, o_err}, 0);
          chk("midrst_xy", {o_pix_x, o_pix_y}, 0);
          chk("midrst_rgb", {o_r, o_g, o_b}, 0);
        end else begin
          drive(1'b1, 1'b1, 8'(px), 8'(ln));
        end
      end
      drive(1'b1, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 8'h00, 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; r = '0; g = '0; b = 8'h5A;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    chk("rst_ctrl", {o_pix_valid, o_sof, o_eol, o_locked, o_err}, 0);
    chk("rst_xy", {o_pix_x, o_pix_y}, 0);
    chk("rst_rgb", {o_r, o_g, o_b}, 0);
    rst = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 8'h00, 8'h00);

    // lock on the third VS fall
    frame(V, -1, -1, 1'b0);
    frame(V, -1, -1, 1'b0);
    chk("prelock_valid", n_valid, 0);
    chk("prelock_locked", o_locked, 0);
    snap();
    frame(V, -1, -1, 1'b0);
    chk("lock_latency", lock_rise, vs_drv + 2);
    chk("f3_locked", o_locked, 1);
    chk("f3_valid", n_valid - b_valid, H * V);
    chk("f3_eol", n_eol - b_eol, V);
    chk("f3_sof", n_sof - b_sof, 1);
    chk("f3_err", n_err - b_err, 0);
    chk("f3_colour", n_bad - b_bad, 0);
    chk("first_strobe_latency", sof_cyc, fpx_drv + 2);

    // short line 1: its 3 pixels pass, then the line error drops lock
    snap();
    frame(V, 1, -1, 1'b0);
    chk("short_err", n_err - b_err, 1);
    chk("short_valid", n_valid - b_valid, H + H - 1);
    chk("short_eol", n_eol - b_eol, 1);
    chk("short_locked", o_locked, 0);

    // broken frame closes at next VS, then two clean frames re-lock
    snap();
    frame(V, -1, -1, 1'b0);
    frame(V, -1, -1, 1'b0);
    chk("retrain_valid", n_valid - b_valid, 0);
    chk("retrain_locked", o_locked, 0);
    snap();
    frame(V, -1, -1, 1'b0);
    chk("relock_locked", o_locked, 1);
    chk("relock_valid", n_valid - b_valid, H * V);

    // one extra line: error on its first pixel, which is dropped
    snap();
    frame(V + 1, -1, -1, 1'b0);
    chk("extra_err", n_err - b_err, 1);
    chk("extra_valid", n_valid - b_valid, H * V);
    chk("extra_locked", o_locked, 0);
    chk("extra_colour", n_bad - b_bad, 0);

    frame(V, -1, -1, 1'b0);
    frame(V, -1, -1, 1'b0);
    // mid-line reset while locked; relock then takes three VS falls
    frame(V, -1, 1, 1'b0);
    frame(V, -1, -1, 1'b0);
    frame(V, -1, -1, 1'b0);
    chk("postrst_wait_locked", o_locked, 0);
    snap();
    frame(V, -1, -1, 1'b0);
    chk("postrst_locked", o_locked, 1);
    chk("postrst_valid", n_valid - b_valid, H * V);

    // VS fall while BLANK_N high
    snap();
    frame(V, -1, -1, 1'b1);
    chk("vsact_err", n_err - b_err, 1);
    chk("vsact_valid", n_valid - b_valid, 0);
    chk("vsact_locked", o_locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
